noc_local_port_buffer: RTL and testbench
========================================

Name: noc_local_port_buffer

Overview:
- Buffering and adaptation stage between the component manager's NoC client port and the router local port.
- TX path: queues flits written by the manager, stamps this node's source address into the header, and drains them into the router under router back-pressure.
- RX path: pops flits announced by the router, queues them for the manager, and raises a level interrupt while data is pending.
- Two independent first-word-fall-through (FWFT) FIFOs; no cross-path coupling.

Parameters:
- NOC_LOCAL_ADR, 0, local port index of this node (3 bits used).
- NOC_X, 0, node X coordinate.
- NOC_Y, 0, node Y coordinate.
- SOC_SIZE_X, 1, log2 of mesh X dimension.
- SOC_SIZE_Y, 1, log2 of mesh Y dimension.
- NOC_DATA_WIDTH, 56, payload bits per flit.
- BUFFER_SIZE, 4, depth of each FIFO; must be a power of two.
- BUFFER_SIZE_LOG2, 2, log2(BUFFER_SIZE).
- STAMP_SRC, 1, when 1 the TX header source fields are overwritten on enqueue.
- Derived: NOC_BUS_SIZE = NOC_DATA_WIDTH + 2*SOC_SIZE_X + 2*SOC_SIZE_Y + 6 (66 by default).

Ports:
- clk_i  in  1  single clock
- rst_n_i  in  1  asynchronous, active-low reset
- client_din_i  in  NOC_BUS_SIZE  TX flit from manager
- client_wr_i  in  1  TX write strobe
- client_wait_o  out  1  TX FIFO full
- client_dout_o  out  NOC_BUS_SIZE  RX FIFO head
- client_nd_o  out  1  RX FIFO non-empty
- client_rd_i  in  1  RX pop strobe
- client_int_o  out  1  level interrupt, equals client_nd_o
- router_din_o  out  NOC_BUS_SIZE  TX FIFO head toward router
- router_wr_o  out  1  TX flit valid
- router_wait_i  in  1  router back-pressure
- router_dout_i  in  NOC_BUS_SIZE  flit offered by router
- router_nd_i  in  1  router has a flit
- router_rd_o  out  1  accept/pop strobe to router
- tx_level_o  out  BUFFER_SIZE_LOG2+1  TX occupancy
- rx_level_o  out  BUFFER_SIZE_LOG2+1  RX occupancy
- ovf_o  out  1  sticky: write attempted while TX full

Behaviour:
- Header layout, MSB first, above the payload: src_x[SOC_SIZE_X], src_y[SOC_SIZE_Y], dst_x[SOC_SIZE_X], dst_y[SOC_SIZE_Y], local_src[3], local_dst[3].

Reset:
- Asserting rst_n_i low asynchronously clears both FIFO pointers and counts, and clears ovf_o.
- While in reset: client_wait_o=0, client_nd_o=0, client_int_o=0, router_wr_o=0, router_rd_o=0, levels=0.
- Data outputs are don't-care while their FIFO is empty.
- Reset taken mid-transfer discards all queued flits; no partial flit survives.

TX path:
- Enqueue on a rising edge when client_wr_i=1 and the FIFO is not full.
- If STAMP_SRC=1, src_x/src_y/local_src are replaced with NOC_X/NOC_Y/NOC_LOCAL_ADR; all other bits are stored unchanged.
- client_wr_i=1 while full: the write is dropped, ovf_o is set and stays set until reset.
- router_wr_o = !tx_empty; router_din_o = head (FWFT).
- A flit transfers on an edge where router_wr_o=1 and router_wait_i=0; the pointer advances on that edge.
- Latency: a flit written into an empty FIFO appears on router_wr_o the following cycle.
- client_wait_o is derived from the registered count.
- Simultaneous enqueue and dequeue: count unchanged. When full, a simultaneous enqueue and dequeue is still refused, because client_wait_o is registered full and no look-ahead is applied.

RX path:
- router_rd_o = router_nd_i && !rx_full (combinational); router_dout_i is captured on the same edge.
- client_nd_o = !rx_empty; client_dout_o = head.
- Pop on client_rd_i && !rx_empty. client_rd_i while empty is ignored, with no state change.
- Simultaneous push and pop: count unchanged.
- When full, no push occurs even if a pop happens in the same cycle.

Pointers and counts:
- Pointers are BUFFER_SIZE_LOG2 bits and wrap modulo BUFFER_SIZE.
- Counts are BUFFER_SIZE_LOG2+1 bits and saturate logically in the range 0..BUFFER_SIZE, never overflowing.

Decomposition:
- Package noc_pkg holds:
  - header field offset/width localparams as functions of SOC_SIZE_X/SOC_SIZE_Y;
  - the NOC_BUS_SIZE formula;
  - LOCAL_ADR_W=3.
- One sub-module, noc_fifo: a parameterised FWFT FIFO (WIDTH, DEPTH, DEPTH_LOG2) with push/pop/full/empty/level, instantiated twice.
- Header stamping and ovf_o live in the top.

Test Plan:
- Reset:
  - Stimulus: hold rst_n_i=0 and toggle all inputs.
  - Required: every control output 0, levels 0.
  - Stimulus: release reset.
  - Required: still idle, no spurious router_wr_o.
- Stamp:
  - Stimulus: NOC_X=1, NOC_Y=0, NOC_LOCAL_ADR=2; write a flit with header 10'h3FF and payload 56'hA5.
  - Required: one cycle later router_din_o header = 10'b1_0_1_1_010_111, payload 56'hA5, router_wr_o=1.
- TX back-pressure and full:
  - Stimulus: router_wait_i=1; write 5 flits.
  - Required: after 4, client_wait_o=1, tx_level_o=4; 5th write sets ovf_o=1.
  - Stimulus: release wait.
  - Required: 4 flits drained in order, one per cycle.
- RX full:
  - Stimulus: router_nd_i held 1 with 6 distinct flits, client_rd_i=0.
  - Required: router_rd_o pulses exactly 4 times, then 0; rx_level_o=4; client_int_o=1.
  - Stimulus: pop 1.
  - Required: router_rd_o reasserts the next cycle.
- RX ordering and wrap:
  - Stimulus: stream 10 flits with concurrent push and pop every cycle.
  - Required: client_dout_o sequence identical to the input; rx_level_o constant at 1 after the first push.
- Mid-operation reset:
  - Stimulus: with 3 flits in each FIFO, pulse rst_n_i low asynchronously between clock edges.
  - Required: outputs clear immediately; after release, no stale flit reappears.

Source files
------------

// File: rtl/noc_pkg.sv
// ============================================================================
// noc_pkg : shared NoC flit layout helpers for the local port buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int LOCAL_ADR_W = 3;

    // Header sits directly above the payload: src_x, src_y, dst_x, dst_y, local_src, local_dst
    function automatic int noc_bus_size(input int dw, input int sx, input int sy);
        return dw + 2 * sx + 2 * sy + 2 * LOCAL_ADR_W;
    endfunction

    function automatic int local_dst_lsb(input int dw);
        return dw;
    endfunction

    function automatic int local_src_lsb(input int dw);
        return dw + LOCAL_ADR_W;
    endfunction

    function automatic int dst_y_lsb(input int dw);
        return dw + 2 * LOCAL_ADR_W;
    endfunction

    function automatic int dst_x_lsb(input int dw, input int sy);
        return dw + 2 * LOCAL_ADR_W + sy;
    endfunction

    function automatic int src_y_lsb(input int dw, input int sx, input int sy);
        return dw + 2 * LOCAL_ADR_W + sy + sx;
    endfunction

    function automatic int src_x_lsb(input int dw, input int sx, input int sy);
        return dw + 2 * LOCAL_ADR_W + 2 * sy + sx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_fifo.sv
// ============================================================================
// noc_fifo : first-word-fall-through FIFO with registered occupancy count
// Revision: 1.0
// ============================================================================
`default_nettype none

module noc_fifo #(
    parameter int WIDTH      = 66,
    parameter int DEPTH      = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      din,
    input  logic                  push,
    input  logic                  pop,
    output logic [WIDTH-1:0]      dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/noc_local_port_buffer.sv
// ============================================================================
// noc_local_port_buffer : TX/RX flit buffering between manager and router port
// Revision: 1.0
// ============================================================================
`default_nettype none

module noc_local_port_buffer
    import noc_pkg::*;
#(
    parameter int NOC_LOCAL_ADR    = 0,
    parameter int NOC_X            = 0,
    parameter int NOC_Y            = 0,
    parameter int SOC_SIZE_X       = 1,
    parameter int SOC_SIZE_Y       = 1,
    parameter int NOC_DATA_WIDTH   = 56,
    parameter int BUFFER_SIZE      = 4,
    parameter int BUFFER_SIZE_LOG2 = 2,
    parameter int STAMP_SRC        = 1,
    localparam int NOC_BUS_SIZE    = noc_bus_size(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y)
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [NOC_BUS_SIZE-1:0]     client_din_i,
    input  logic                        client_wr_i,
    output logic                        client_wait_o,
    output logic [NOC_BUS_SIZE-1:0]     client_dout_o,
    output logic                        client_nd_o,
    input  logic                        client_rd_i,
    output logic                        client_int_o,
    output logic [NOC_BUS_SIZE-1:0]     router_din_o,
    output logic                        router_wr_o,
    input  logic                        router_wait_i,
    input  logic [NOC_BUS_SIZE-1:0]     router_dout_i,
    input  logic                        router_nd_i,
    output logic                        router_rd_o,
    output logic [BUFFER_SIZE_LOG2:0]   tx_level_o,
    output logic [BUFFER_SIZE_LOG2:0]   rx_level_o,
    output logic                        ovf_o
);

    localparam int SRC_X_LSB     = src_x_lsb(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y);
    localparam int SRC_Y_LSB     = src_y_lsb(NOC_DATA_WIDTH, SOC_SIZE_X, SOC_SIZE_Y);
    localparam int LOCAL_SRC_LSB = local_src_lsb(NOC_DATA_WIDTH);

    logic [NOC_BUS_SIZE-1:0] stamped;
    logic                    tx_full;
    logic                    tx_empty;
    logic                    rx_full;
    logic                    rx_empty;
    logic                    ovf;

    generate
        if (STAMP_SRC != 0) begin : g_stamp
            always_comb begin
                stamped = client_din_i;
                stamped[SRC_X_LSB +: SOC_SIZE_X]      = SOC_SIZE_X'(NOC_X);
                stamped[SRC_Y_LSB +: SOC_SIZE_Y]      = SOC_SIZE_Y'(NOC_Y);
                stamped[LOCAL_SRC_LSB +: LOCAL_ADR_W] = LOCAL_ADR_W'(NOC_LOCAL_ADR);
            end
        end else begin : g_no_stamp
            assign stamped = client_din_i;
        end
    endgenerate

    noc_fifo #(
        .WIDTH      (NOC_BUS_SIZE),
        .DEPTH      (BUFFER_SIZE),
        .DEPTH_LOG2 (BUFFER_SIZE_LOG2)
    ) u_tx_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .din   (stamped),
        .push  (client_wr_i),
        .pop   (!router_wait_i),
        .dout  (router_din_o),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level_o)
    );

    assign client_wait_o = tx_full;
    assign router_wr_o   = !tx_empty;

    // Reset gates the accept strobe so the router never sees a pop while we are held
    assign router_rd_o = rst_n_i && router_nd_i && !rx_full;

    noc_fifo #(
        .WIDTH      (NOC_BUS_SIZE),
        .DEPTH      (BUFFER_SIZE),
        .DEPTH_LOG2 (BUFFER_SIZE_LOG2)
    ) u_rx_fifo (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .din   (router_dout_i),
        .push  (router_rd_o),
        .pop   (client_rd_i),
        .dout  (client_dout_o),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level_o)
    );

    assign client_nd_o  = !rx_empty;
    assign client_int_o = !rx_empty;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf <= 1'b0;
        end else if (client_wr_i && tx_full) begin
            ovf <= 1'b1;
        end
    end

    assign ovf_o = ovf;

endmodule

`default_nettype wire

// File: tb/tb_noc_local_port_buffer.sv
// ============================================================================
// tb_noc_local_port_buffer : randomized bench against a queue-based flit model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_noc_local_port_buffer;

    localparam int BW = 66;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] client_din = '0;
    logic          client_wr = 1'b0;
    logic          client_wait;
    logic [BW-1:0] client_dout;
    logic          client_nd;
    logic          client_rd = 1'b0;
    logic          client_int;
    logic [BW-1:0] router_din;
    logic          router_wr;
    logic          router_wait = 1'b0;
    logic [BW-1:0] router_dout = '0;
    logic          router_nd = 1'b0;
    logic          router_rd;
    logic [2:0]    tx_level;
    logic [2:0]    rx_level;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    logic [BW-1:0] txq[$];
    logic [BW-1:0] rxq[$];
    bit            m_ovf = 1'b0;
    logic          last_rd;

    noc_local_port_buffer #(
        .NOC_LOCAL_ADR (2),
        .NOC_X         (1),
        .NOC_Y         (0)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .client_din_i  (client_din),
        .client_wr_i   (client_wr),
        .client_wait_o (client_wait),
        .client_dout_o (client_dout),
        .client_nd_o   (client_nd),
        .client_rd_i   (client_rd),
        .client_int_o  (client_int),
        .router_din_o  (router_din),
        .router_wr_o   (router_wr),
        .router_wait_i (router_wait),
        .router_dout_i (router_dout),
        .router_nd_i   (router_nd),
        .router_rd_o   (router_rd),
        .tx_level_o    (tx_level),
        .rx_level_o    (rx_level),
        .ovf_o         (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // This node is (x=1, y=0, local=2); destination fields and payload pass through
    function automatic logic [BW-1:0] stamp(input logic [BW-1:0] f);
        return {1'b1, 1'b0, f[63], f[62], 3'd2, f[58:56], f[55:0]};
    endfunction

    function automatic logic [BW-1:0] rand_flit();
        return {$urandom(), $urandom(), 2'($urandom())};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_wait"}, client_wait, 1'b0);
        check({tag, "_nd"}, client_nd, 1'b0);
        check({tag, "_int"}, client_int, 1'b0);
        check({tag, "_rwr"}, router_wr, 1'b0);
        check({tag, "_rrd"}, router_rd, 1'b0);
        check({tag, "_txl"}, tx_level, 3'd0);
        check({tag, "_rxl"}, rx_level, 3'd0);
        check({tag, "_ovf"}, ovf, 1'b0);
    endtask

    // Called at a falling edge: drive, check against the model, then advance the model
    task automatic cycle(input bit wr, input logic [BW-1:0] din, input bit wt,
                         input bit nd, input logic [BW-1:0] rdat, input bit rd);
        bit tx_full, rx_acc, rx_pop;
        client_wr   = wr;
        client_din  = din;
        router_wait = wt;
        router_nd   = nd;
        router_dout = rdat;
        client_rd   = rd;
        #1;
        check("router_wr", router_wr, txq.size() != 0);
        check("client_wait", client_wait, txq.size() == D);
        check("tx_level", tx_level, txq.size());
        if (txq.size() != 0) check("router_din", router_din, txq[0]);
        check("router_rd", router_rd, nd && rxq.size() < D);
        check("client_nd", client_nd, rxq.size() != 0);
        check("client_int", client_int, rxq.size() != 0);
        check("rx_level", rx_level, rxq.size());
        if (rxq.size() != 0) check("client_dout", client_dout, rxq[0]);
        check("ovf", ovf, m_ovf);
        last_rd = router_rd;
        @(posedge clk);
        tx_full = (txq.size() == D);
        if (txq.size() != 0 && !wt) void'(txq.pop_front());
        if (wr) begin
            if (tx_full) m_ovf = 1'b1;
            else         txq.push_back(stamp(din));
        end
        rx_acc = nd && rxq.size() < D;
        rx_pop = rd && rxq.size() != 0;
        if (rx_pop) void'(rxq.pop_front());
        if (rx_acc) rxq.push_back(rdat);
        @(negedge clk);
    endtask

    initial begin
        logic [BW-1:0] saved[4];
        int pulses;

        // Reset held: inputs toggle but everything stays idle
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            client_wr   = 1'($urandom());
            client_din  = rand_flit();
            client_rd   = 1'($urandom());
            router_wait = 1'($urandom());
            router_nd   = 1'b1;
            router_dout = rand_flit();
            #1;
            check_idle("rst_hold");
            @(negedge clk);
        end
        client_wr = 1'b0; client_rd = 1'b0; router_nd = 1'b0; router_wait = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) cycle(0, '0, 0, 0, '0, 0);

        // Source stamping
        cycle(1, {10'h3FF, 56'hA5}, 1, 0, '0, 0);
        check("stamp_hdr", router_din[65:56], 10'b1_0_1_1_010_111);
        check("stamp_pay", router_din[55:0], 56'hA5);
        check("stamp_wr", router_wr, 1'b1);
        cycle(0, '0, 0, 0, '0, 0);

        // TX back-pressure, full and overflow
        for (int i = 0; i < 5; i++) begin
            logic [BW-1:0] f;
            f = rand_flit();
            if (i < 4) saved[i] = stamp(f);
            cycle(1, f, 1, 0, '0, 0);
        end
        check("txfull_wait", client_wait, 1'b1);
        check("txfull_level", tx_level, 3'd4);
        check("txfull_ovf", ovf, 1'b1);
        for (int i = 0; i < 4; i++) begin
            client_wr = 1'b0; router_wait = 1'b0;
            #1;
            check("drain_order", router_din, saved[i]);
            check("drain_valid", router_wr, 1'b1);
            @(negedge clk);
            void'(txq.pop_front());
        end
        cycle(0, '0, 0, 0, '0, 0);

        // RX full: router offers 6 flits, only 4 accepted
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, '0, 0, 1, BW'(64'h100 + i), 0);
            pulses += int'(last_rd);
        end
        check("rxfull_pulses", pulses, 4);
        check("rxfull_level", rx_level, 3'd4);
        check("rxfull_int", client_int, 1'b1);
        cycle(0, '0, 0, 1, BW'(64'h200), 1);
        check("rxfull_blocked", last_rd, 1'b0);
        cycle(0, '0, 0, 1, BW'(64'h201), 0);
        check("rxfull_reassert", last_rd, 1'b1);
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 0, '0, 1);

        // RX ordering and pointer wrap with concurrent push/pop
        cycle(0, '0, 0, 1, BW'(64'h300), 0);
        for (int i = 1; i <= 10; i++) begin
            cycle(0, '0, 0, 1, BW'(64'h300 + i), 1);
            check("stream_level", rx_level, 3'd1);
        end
        cycle(0, '0, 0, 0, '0, 1);

        // Mid-operation asynchronous reset
        for (int i = 0; i < 3; i++) cycle(1, rand_flit(), 1, 1, rand_flit(), 0);
        check("pre_rst_tx", tx_level, 3'd3);
        check("pre_rst_rx", rx_level, 3'd3);
        client_wr = 1'b0; router_nd = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_idle("async_rst");
        #1 rst_n = 1'b1;
        txq.delete();
        rxq.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, '0, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), rand_flit(), 1'($urandom()),
                  1'($urandom()), rand_flit(), 1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
